// File: rtl/kt_pkg.sv
// Shared constants and requester id type for the kt-term multiplier sharing logic.
package kt_pkg;

  localparam int unsigned KT_DATA_W = 64;
  localparam int unsigned KT_N_REQ  = 4;

  typedef logic [$clog2(KT_N_REQ)-1:0] kt_id_t;

  localparam kt_id_t KT1 = kt_id_t'(0);
  localparam kt_id_t KT2 = kt_id_t'(1);
  localparam kt_id_t KT3 = kt_id_t'(2);
  localparam kt_id_t KT4 = kt_id_t'(3);

endpackage

// File: rtl/kt_tag_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; pop_data is the head entry.
// Callers must not push when full (unless also popping) nor pop when empty.
module kt_tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kt_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ kt-term requesters,
// with in-order result routing. Define KT_ARB_ERR_EN to add the sticky arb_err flag.
module kt_mul_arbiter
  import kt_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = KT_DATA_W,
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned MUL_LAT   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_rdy,
  output logic                    mul_tvalid,
  input  logic                    mul_tready,
  output logic [DATA_W-1:0]       mul_a,
  output logic [DATA_W-1:0]       mul_b,
  input  logic                    mul_res_vld,
  input  logic [DATA_W-1:0]       mul_res,
  output logic [N_REQ-1:0]        res_vld,
  output logic [DATA_W-1:0]       res_data
`ifdef KT_ARB_ERR_EN
  ,
  output logic                    arb_err
`endif
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH+1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("kt_mul_arbiter: N_REQ must be 2..8");
  end
  if (MUL_LAT < 1) begin : g_bad_mul_lat
    $error("kt_mul_arbiter: MUL_LAT must be at least 1");
  end

  logic [ID_W-1:0]  rr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  issue_id;
  logic [ID_W-1:0]  pop_id;
  logic             grant_found;
  logic             grant_ok;
  logic             issue_free;
  logic             hs;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  int unsigned      idx;

  assign issue_free = !mul_tvalid || mul_tready;
  assign hs         = mul_tvalid && mul_tready;
  assign pop        = mul_res_vld && !fifo_empty;
  assign push       = hs && (!fifo_full || pop);

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_vld[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Room check counts the tag being pushed this cycle; a same-cycle pop is not credited.
  assign grant_ok = !rst && issue_free && grant_found &&
                    ((32'(fifo_count) + 32'(hs)) < TAG_DEPTH);

  always_comb begin
    req_rdy = '0;
    if (grant_ok) req_rdy[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_tvalid <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      issue_id   <= '0;
      rr         <= '0;
    end else if (grant_ok) begin
      mul_tvalid <= 1'b1;
      mul_a      <= req_a[32'(grant_id)*DATA_W +: DATA_W];
      mul_b      <= req_b[32'(grant_id)*DATA_W +: DATA_W];
      issue_id   <= grant_id;
      rr         <= (32'(grant_id) == N_REQ-1) ? '0 : grant_id + 1'b1;
    end else if (mul_tready) begin
      mul_tvalid <= 1'b0;
    end
  end

  kt_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (issue_id),
    .pop       (pop),
    .pop_data  (pop_id),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld  <= '0;
      res_data <= '0;
    end else begin
      res_vld <= '0;
      if (pop) begin
        res_vld[pop_id] <= 1'b1;
        res_data        <= mul_res;
      end
    end
  end

`ifdef KT_ARB_ERR_EN
  localparam int unsigned BLANK_W = $clog2(MUL_LAT+2);

  logic [BLANK_W-1:0] blank_cnt;

  // Blanking covers products still inside the multiplier when reset hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= BLANK_W'(MUL_LAT+1);
      arb_err   <= 1'b0;
    end else begin
      if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
      if ((mul_res_vld && fifo_empty && blank_cnt == '0) ||
          (hs && fifo_full && !pop))
        arb_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kt_mul_arbiter.sv
// Directed self-checking bench for kt_mul_arbiter with a behavioural pipelined multiplier.
module tb_kt_mul_arbiter;
  import kt_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_rdy;
  logic            mul_tvalid;
  logic            mul_tready;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic            mul_res_vld;
  logic [DW-1:0]   mul_res;
  logic [N-1:0]    res_vld;
  logic [DW-1:0]   res_data;
`ifdef KT_ARB_ERR_EN
  logic            arb_err;
`endif

  always #5 clk = ~clk;

  kt_mul_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .TAG_DEPTH (4),
    .MUL_LAT   (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rdy     (req_rdy),
    .mul_tvalid  (mul_tvalid),
    .mul_tready  (mul_tready),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_res_vld (mul_res_vld),
    .mul_res     (mul_res),
    .res_vld     (res_vld),
    .res_data    (res_data)
`ifdef KT_ARB_ERR_EN
    ,
    .arb_err     (arb_err)
`endif
  );

  real op_a [N];
  real op_b [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = $realtobits(op_a[i]);
      req_b[i*DW +: DW] = $realtobits(op_b[i]);
    end
  end

  // Behavioural multiplier: fixed latency `lat`, never stalls its result side.
  int            lat;
  logic          inj;
  bit [15:0]     pv;
  logic [63:0]   pd [16];

  always @(posedge clk) begin
    pv    <= {pv[14:0], (mul_tvalid === 1'b1) && mul_tready};
    pd[0] <= $realtobits($bitstoreal(mul_a) * $bitstoreal(mul_b));
    for (int i = 1; i < 16; i++) pd[i] <= pd[i-1];
  end

  assign mul_res_vld = pv[lat-1] | inj;
  assign mul_res     = pd[lat-1];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] prod;
  } sb_t;

  sb_t          sb [$];
  int           n_res = 0;
  int           cyc = 0;
  logic [N-1:0] last_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t e;
    last_gnt = '0;
    if (!rst) begin
      if (res_vld != '0) begin
        n_res++;
        if (sb.size() == 0) chk("unexpected_res", 64'(res_vld), 64'd0);
        else begin
          e = sb.pop_front();
          chk("res_route", 64'(res_vld), 64'(1) << e.id);
          chk("res_data", res_data, e.prod);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          e.id   = i;
          e.a    = $realtobits(op_a[i]);
          e.b    = $realtobits(op_b[i]);
          e.prod = $realtobits(op_a[i] * op_b[i]);
          sb.push_back(e);
          last_gnt[i] = 1'b1;
        end
      end
    end
  end

  // Advance to just after the next edge; granted requesters present a fresh operand.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_gnt[i]) op_a[i] = op_a[i] + 1.0;
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    req_vld = '0;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    req_vld = '0;
    while (sb.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    repeat (8) step();
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] rdy;
  } vec_t;

  vec_t vt [16];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n0;
    int first_res;
    int gq [$];
    logic [63:0] held_a;
    logic [63:0] held_b;

    vt[0]  = '{4'b1111, 4'b0001};
    vt[1]  = '{4'b1111, 4'b0010};
    vt[2]  = '{4'b1111, 4'b0100};
    vt[3]  = '{4'b1111, 4'b1000};
    vt[4]  = '{4'b1111, 4'b0001};
    vt[5]  = '{4'b1111, 4'b0010};
    vt[6]  = '{4'b1111, 4'b0100};
    vt[7]  = '{4'b1111, 4'b1000};
    vt[8]  = '{4'b1010, 4'b0010};
    vt[9]  = '{4'b1010, 4'b1000};
    vt[10] = '{4'b0100, 4'b0100};
    vt[11] = '{4'b0001, 4'b0001};
    vt[12] = '{4'b0000, 4'b0000};
    vt[13] = '{4'b1001, 4'b1000};
    vt[14] = '{4'b1000, 4'b1000};
    vt[15] = '{4'b0110, 4'b0010};

    rst        = 1'b1;
    req_vld    = '0;
    mul_tready = 1'b1;
    inj        = 1'b0;
    lat        = 6;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 1.0 + i;
      op_b[i] = 2.0;
    end

    // Reset state, including no grant while rst is held with requests pending.
    repeat (3) step();
    req_vld = '1;
    @(negedge clk);
    chk("rst_req_rdy_held", 64'(req_rdy), 64'd0);
    step();
    rst     = 1'b0;
    req_vld = '0;
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_mul_tvalid", 64'(mul_tvalid), 64'd0);
    chk("rst_mul_a", mul_a, 64'd0);
    chk("rst_mul_b", mul_b, 64'd0);
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
`ifdef KT_ARB_ERR_EN
    chk("rst_arb_err", 64'(arb_err), 64'd0);
`endif

    // Single requester, 2.0 * 3.0 with latency 6.
    step();
    op_a[0] = 2.0;
    op_b[0] = 3.0;
    req_vld = 4'b0001;
    @(negedge clk);
    chk("t1_req_rdy", 64'(req_rdy), 64'h1);
    step();
    req_vld = '0;
    @(negedge clk);
    chk("t1_mul_tvalid", 64'(mul_tvalid), 64'd1);
    chk("t1_mul_a", mul_a, 64'h4000000000000000);
    chk("t1_mul_b", mul_b, 64'h4008000000000000);
    repeat (6) @(negedge clk);
    chk("t1_res_vld_early", 64'(res_vld), 64'd0);
    @(negedge clk);
    chk("t1_res_vld", 64'(res_vld), 64'h1);
    chk("t1_res_data", res_data, 64'h4018000000000000);
    drain();

    // Round-robin vectors from a fresh rr=0, short latency so the FIFO never fills.
    reset_dut();
    lat = 2;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 1.5 + i;
      op_b[i] = 2.0 + 0.25 * i;
    end
    for (int r = 0; r < 16; r++) begin
      req_vld = vt[r].vld;
      @(negedge clk);
      chk($sformatf("rr_row%0d", r), 64'(req_rdy), 64'(vt[r].rdy));
      step();
    end
    drain();

    // Backpressure: issue register must hold and no grants while tready is low.
    req_vld = '1;
    repeat (3) step();
    mul_tready = 1'b0;
    held_a = sb[sb.size()-1].a;
    held_b = sb[sb.size()-1].b;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      chk("bp_mul_tvalid", 64'(mul_tvalid), 64'd1);
      chk("bp_mul_a", mul_a, held_a);
      chk("bp_mul_b", mul_b, held_b);
      step();
    end
    mul_tready = 1'b1;
    repeat (4) step();
    drain();

    // FIFO full: depth 4, latency 6.
    lat = 6;
    first_res = -1;
    gq.delete();
    req_vld = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((req_vld & req_rdy) != '0) gq.push_back(cyc);
      if (mul_res_vld && first_res < 0) first_res = cyc;
      step();
    end
    req_vld = '0;
    chk("ff_enough_grants", 64'(gq.size() >= 5), 64'd1);
    if (gq.size() >= 5) begin
      chk("ff_burst_of_4", 64'(gq[3] - gq[0]), 64'd3);
      chk("ff_first_res_lat", 64'(first_res), 64'(gq[0] + 7));
      chk("ff_resume", 64'(gq[4]), 64'(first_res + 1));
    end
    drain();

    // Reset with three products in flight.
    reset_dut();
    lat = 6;
    req_vld = '1;
    repeat (3) step();
    req_vld = '0;
    repeat (2) step();
    reset_dut();
    n0 = n_res;
    repeat (12) step();
    chk("rf_orphans", 64'(n_res - n0), 64'd0);
`ifdef KT_ARB_ERR_EN
    chk("rf_arb_err", 64'(arb_err), 64'd0);
`endif
    op_a[2] = 1.5;
    op_b[2] = 4.0;
    n0 = n_res;
    req_vld = 4'b0100;
    @(negedge clk);
    chk("rf_req_rdy", 64'(req_rdy), 64'h4);
    step();
    req_vld = '0;
    drain();
    chk("rf_completed", 64'(n_res - n0), 64'd1);

`ifdef KT_ARB_ERR_EN
    // Spurious result with an empty FIFO, well outside the blanking window.
    reset_dut();
    repeat (20) step();
    inj = 1'b1;
    @(negedge clk);
    chk("err_pre", 64'(arb_err), 64'd0);
    step();
    inj = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(arb_err), 64'd1);
    repeat (5) step();
    @(negedge clk);
    chk("err_sticky", 64'(arb_err), 64'd1);
    reset_dut();
    @(negedge clk);
    chk("err_cleared", 64'(arb_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/kt_mul_arbiter.md
# kt_mul_arbiter

- Shares one pipelined double-precision multiplier (AXI-stream, non-blocking result channel) among up to `N_REQ` kt-term requesters (kt_1, kt_2, …).
- Arbitrates operand pairs round-robin and issues one product per cycle.
- Tracks which requester owns each in-flight product and routes every result back as a one-cycle valid pulse on that requester's strobe.
- Sits between the kt-term stages and the shared `floating_point_0` multiplier instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 64, operand/result width (IEEE-754 double)
- `TAG_DEPTH`, 8, in-flight tag FIFO entries; must be ≥ multiplier latency + 2
- `MUL_LAT`, 6, multiplier latency in cycles; used only for the post-reset error blanking window

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `req_vld`  in  N_REQ  requester i has an operand pair
- `req_a`  in  N_REQ*DATA_W  operand A, slice i
- `req_b`  in  N_REQ*DATA_W  operand B, slice i
- `req_rdy`  out  N_REQ  one-hot grant; pair i is accepted when `req_vld[i] & req_rdy[i]`
- `mul_tvalid`  out  1  drives multiplier `s_axis_a_tvalid` and `s_axis_b_tvalid`
- `mul_tready`  in  1  AND of multiplier a/b tready
- `mul_a`  out  DATA_W  multiplier operand A
- `mul_b`  out  DATA_W  multiplier operand B
- `mul_res_vld`  in  1  multiplier `m_axis_result_tvalid`; its tready is tied 1 outside this block
- `mul_res`  in  DATA_W  multiplier result
- `res_vld`  out  N_REQ  one-hot result strobe
- `res_data`  out  DATA_W  result, shared by all requesters
- `arb_err`  out  1  sticky error flag; present only with `KT_ARB_ERR_EN`

## Operation
- **Issue register.** Holds `mul_a`, `mul_b`, `mul_tvalid` and the granted id.
  - It is free when `!mul_tvalid | mul_tready`.
- **Grant condition.** A grant is made only when all three hold:
  - the issue register is free;
  - the tag FIFO is not full (counting the entry pushed this cycle);
  - some `req_vld` is set.
- **Arbitration.**
  - Round-robin search starts at pointer `rr`.
  - The winner g gets `req_rdy[g]=1` combinationally. All other `req_rdy` bits are 0.
  - On accept, operands load into the issue register and `rr` becomes (g+1) mod N_REQ.
  - With no accept, `rr` holds.
- **Tag FIFO.**
  - Push the granted id on the multiplier handshake (`mul_tvalid & mul_tready`).
  - Pop on `mul_res_vld`. The popped id drives `res_vld` and `res_data` one cycle later.
  - Simultaneous push and pop is legal and leaves occupancy unchanged.
- **Orphan results.** A `mul_res_vld` while the FIFO is empty is dropped and produces no `res_vld`. This covers products in flight across reset.

## Timing
Reset values:
- `req_rdy` = 0
- `mul_tvalid` = 0
- `mul_a` = 0, `mul_b` = 0
- `res_vld` = 0
- `res_data` = 0
- `rr` = 0
- FIFO empty
- `arb_err` = 0

Latency and throughput:
- Accept at cycle t. `mul_tvalid` is high at t+1. The product arrives at t+1+L, where L is the core latency. `res_vld` pulses at t+2+L.
- Sustained throughput is one product per cycle while `mul_tready`=1 and the FIFO is not full.
- If `mul_tready` is low, the issue register holds and no grant is made. `req_rdy` is 0 that cycle.

Reset mid-operation:
- Flushes the FIFO and the issue register.
- Results already in the multiplier are dropped as orphans.

Ordering:
- Results return strictly in issue order, because the multiplier is in-order.

## Configuration
- `KT_ARB_ERR_EN` defined:
  - `arb_err` exists.
  - It sets on an orphan result, or on a push to a full FIFO while the pop side is idle.
  - A down-counter of `MUL_LAT+1` cycles, loaded on reset, blanks orphan detection so that reset flushes do not raise it.
  - It clears only on `rst`.
- `KT_ARB_ERR_EN` undefined: the port, the counter and the detection logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `kt_pkg`:
  - `KT_DATA_W`
  - the requester id type (`logic [$clog2(N_REQ)-1:0]`)
  - the requester index constants (KT1, KT2, …)
- Sub-module `kt_tag_fifo`: a synchronous FIFO with count, full and empty. It is instantiated once for the id tags.
- The arbiter, issue register and result router are in the top module.

## Test plan
1. **Single requester.** Requester 0 only, A=2.0, B=3.0, L=6. Expect:
   - `req_rdy[0]` the same cycle;
   - `mul_tvalid` at t+1;
   - `res_vld`=0001 and `res_data`=6.0 at t+8.
2. **All requesters, round-robin.** All four `req_vld` held high for 8 cycles. Expect:
   - grant order 0,1,2,3,0,1,2,3;
   - `res_vld` order identical;
   - each `res_data` equal to that requester's A×B.
3. **Backpressure.** Hold `mul_tready`=0 for 3 cycles mid-stream. Expect:
   - `req_rdy`=0 and `mul_a`/`mul_b` stable throughout;
   - no lost or duplicated products.
4. **FIFO full.** `TAG_DEPTH`=4 with a model multiplier of latency 6. Expect:
   - grants stall after 4 outstanding;
   - grants resume on the cycle after the first `mul_res_vld` pop.
5. **Reset mid-flight.** Assert `rst` with 3 products in flight. Expect:
   - no `res_vld` for those products;
   - with `KT_ARB_ERR_EN`, `arb_err` stays 0;
   - the next request after reset completes normally.
6. **Error flag** (`KT_ARB_ERR_EN` only). Inject a spurious `mul_res_vld` 20 cycles after reset with the FIFO empty. Expect `arb_err`=1 the following cycle, sticky until `rst`.
